// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants and lane result type for the half-adder array
package half_adder_pkg;

  // Classic single-lane half adder unless the instantiator asks for more lanes.
  localparam int HA_DEFAULT_WIDTH = 1;

  // Two-bit arithmetic result of one lane: {cout, sum} = a + b.
  typedef struct packed {
    logic cout;
    logic sum;
  } ha_result_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single combinational 1-bit half-adder lane
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output ha_result_t res
);

  // Sum and carry of two one-bit operands; they can never both be 1.
  assign res.sum  = a ^ b;
  assign res.cout = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// rtl/half_adder.sv - WIDTH independent half-adder lanes with combinational and registered outputs
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic             out_valid
);

  ha_result_t [WIDTH-1:0] lane;

  // One cell per lane; no carry crosses lane boundaries, so an X on one
  // lane's inputs stays confined to that lane's outputs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .res (lane[i])
    );
    assign sum[i]  = lane[i].sum;
    assign cout[i] = lane[i].cout;
  end

  // Output stage: capture on in_valid, hold otherwise; valid is a one-cycle
  // echo of in_valid. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder at WIDTH=1 and WIDTH=8
module tb_half_adder;

  logic       clk;
  logic       rst_n;

  logic [0:0] a1, b1, sum1, cout1, sum_q1, cout_q1;
  logic       in_valid1, out_valid1;

  logic [7:0] a8, b8, sum8, cout8, sum_q8, cout_q8;
  logic       in_valid8, out_valid8;

  int n_cmp;
  int n_err;

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .in_valid  (in_valid1),
    .sum       (sum1),
    .cout      (cout1),
    .sum_q     (sum_q1),
    .cout_q    (cout_q1),
    .out_valid (out_valid1)
  );

  half_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .b         (b8),
    .in_valid  (in_valid8),
    .sum       (sum8),
    .cout      (cout8),
    .sum_q     (sum_q8),
    .cout_q    (cout_q8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic [7:0] cout;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each lane is an independent two-bit addition a[i] + b[i].
  function automatic void ref_add(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] s, output logic [7:0] c);
    logic [1:0] r;
    for (int i = 0; i < 8; i++) begin
      r    = 2'(a[i]) + 2'(b[i]);
      s[i] = r[0];
      c[i] = r[1];
    end
  endfunction

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t       tab1 [4];
  vec_t       tab8 [5];
  logic [7:0] es, ec;

  initial begin
    n_cmp = 0;
    n_err = 0;

    tab1[0] = '{a: 8'h0, b: 8'h0, sum: 8'h0, cout: 8'h0};
    tab1[1] = '{a: 8'h0, b: 8'h1, sum: 8'h1, cout: 8'h0};
    tab1[2] = '{a: 8'h1, b: 8'h0, sum: 8'h1, cout: 8'h0};
    tab1[3] = '{a: 8'h1, b: 8'h1, sum: 8'h0, cout: 8'h1};

    tab8[0] = '{a: 8'hF0, b: 8'hCC, sum: 8'h3C, cout: 8'hC0};
    tab8[1] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 8'h00};
    tab8[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'h00, cout: 8'hFF};
    tab8[3] = '{a: 8'hFF, b: 8'h00, sum: 8'hFF, cout: 8'h00};
    tab8[4] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, cout: 8'h00};

    rst_n     = 1'b0;
    a1        = '0;
    b1        = '0;
    in_valid1 = 1'b0;
    a8        = '0;
    b8        = '0;
    in_valid8 = 1'b0;
    #12;

    check("reset_sum_q1",  8'(sum_q1),  8'h0);
    check("reset_cout_q1", 8'(cout_q1), 8'h0);
    check("reset_ov1",     8'(out_valid1), 8'h0);
    check("reset_sum_q8",  sum_q8,  8'h00);
    check("reset_cout_q8", cout_q8, 8'h00);
    check("reset_ov8",     8'(out_valid8), 8'h0);

    #1 rst_n = 1'b1;
    step();

    // WIDTH=1 exhaustive, combinational, 10 ns hold each.
    for (int i = 0; i < 4; i++) begin
      a1 = tab1[i].a[0:0];
      b1 = tab1[i].b[0:0];
      #10;
      check($sformatf("w1_sum[%0d]", i),  8'(sum1),  tab1[i].sum);
      check($sformatf("w1_cout[%0d]", i), 8'(cout1), tab1[i].cout);
    end

    // WIDTH=8 table: combinational now, registered one edge later.
    for (int i = 0; i < 5; i++) begin
      a8 = tab8[i].a;
      b8 = tab8[i].b;
      in_valid8 = 1'b1;
      #1;
      check($sformatf("w8_sum[%0d]", i),  sum8,  tab8[i].sum);
      check($sformatf("w8_cout[%0d]", i), cout8, tab8[i].cout);
      check($sformatf("w8_excl[%0d]", i), sum8 & cout8, 8'h00);
      step();
      check($sformatf("w8_sum_q[%0d]", i),  sum_q8,  tab8[i].sum);
      check($sformatf("w8_cout_q[%0d]", i), cout_q8, tab8[i].cout);
      check($sformatf("w8_ov[%0d]", i),     8'(out_valid8), 8'h1);
    end
    in_valid8 = 1'b0;

    // WIDTH=1 registered capture then hold.
    a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
    step();
    check("w1_cap_sum_q",  8'(sum_q1),  8'h0);
    check("w1_cap_cout_q", 8'(cout_q1), 8'h1);
    check("w1_cap_ov",     8'(out_valid1), 8'h1);
    a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b0;
    step();
    check("w1_hold_sum_q",  8'(sum_q1),  8'h0);
    check("w1_hold_cout_q", 8'(cout_q1), 8'h1);
    check("w1_hold_ov",     8'(out_valid1), 8'h0);

    // WIDTH=8 hold after the table stream ended (last capture was AA/55).
    a8 = 8'h12; b8 = 8'h34;
    step();
    check("w8_hold_sum_q",  sum_q8,  8'hFF);
    check("w8_hold_cout_q", cout_q8, 8'h00);
    check("w8_hold_ov",     8'(out_valid8), 8'h0);

    // Lane isolation: X on lane 3 must not reach other lanes.
    a8 = 8'b1010_x101; b8 = 8'b0110_0011;
    #1;
    check("x_iso_sum",  8'(^(sum8 & 8'hF7) === 1'bx),  8'h0);
    check("x_iso_cout", 8'(^(cout8 & 8'hF7) === 1'bx), 8'h0);

    // Random streaming, 16 back-to-back captures.
    in_valid8 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ref_add(a8, b8, es, ec);
      #1;
      check($sformatf("rnd_sum[%0d]", k),  sum8,  es);
      check($sformatf("rnd_cout[%0d]", k), cout8, ec);
      step();
      check($sformatf("rnd_sum_q[%0d]", k),  sum_q8,  es);
      check($sformatf("rnd_cout_q[%0d]", k), cout_q8, ec);
      check($sformatf("rnd_ov[%0d]", k),     8'(out_valid8), 8'h1);
    end

    // Reset mid-stream.
    a8 = 8'hFF; b8 = 8'h01;
    step();
    check("mid_pre_sum_q",  sum_q8,  8'hFE);
    check("mid_pre_cout_q", cout_q8, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum_q",  sum_q8,  8'h00);
    check("mid_rst_cout_q", cout_q8, 8'h00);
    check("mid_rst_ov",     8'(out_valid8), 8'h0);
    check("mid_rst_sum",    sum8,  8'hFE);
    check("mid_rst_cout",   cout8, 8'h01);
    step();
    check("rst_held_sum_q", sum_q8, 8'h00);
    check("rst_held_ov",    8'(out_valid8), 8'h0);

    // Post-reset idle for three edges.
    in_valid8 = 1'b0;
    in_valid1 = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("idle_sum_q[%0d]", k),  sum_q8,  8'h00);
      check($sformatf("idle_cout_q[%0d]", k), cout_q8, 8'h00);
      check($sformatf("idle_ov[%0d]", k),     8'(out_valid8), 8'h0);
      check($sformatf("idle_ov1[%0d]", k),    8'(out_valid1), 8'h0);
    end

    // First capture after reset.
    a8 = 8'h0F; b8 = 8'h3C; in_valid8 = 1'b1;
    ref_add(a8, b8, es, ec);
    step();
    check("post_sum_q",  sum_q8,  es);
    check("post_cout_q", cout_q8, ec);
    check("post_ov",     8'(out_valid8), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_half_adder
